// File: rtl/counter_mod_n.sv
// Synchronous modulo-N up/down counter with load, terminal count and wrap pulse.
// Define COUNTER_MOD_N_SAT_EN to make the counter hold at its bounds instead of wrapping.
module counter_mod_n #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 6
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CNT,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] OUT,
  output logic             TC,
  output logic             WRAP
);

  localparam logic [WIDTH:0] MAX =
    (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAXW =
    WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE =
    (WIDTH+1)'(1);

  generate
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("counter_mod_n: WIDTH %0d out of 1..16",
             WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH))
    begin : g_bad_mod
      $error("counter_mod_n: MODULUS %0d illegal",
             MODULUS);
    end
  endgenerate

  logic [WIDTH:0]   cur;
  logic [WIDTH-1:0] nxt;
  logic             nxt_wrap;

  // Next count: load clamps to the top state; a forced
  // out-of-range state falls back to 0 on a count edge.
  always_comb begin
    cur      = {1'b0, OUT};
    nxt      = OUT;
    nxt_wrap = 1'b0;
    unique case (1'b1)
      LD: begin
        if ({1'b0, DIN} > MAX) nxt = MAXW;
        else                   nxt = DIN;
      end
      (!LD && CNT): begin
        if (cur > MAX) begin
          nxt = '0;
        end else if (UP) begin
          if (cur == MAX) begin
`ifdef COUNTER_MOD_N_SAT_EN
            nxt = MAXW;
`else
            nxt      = '0;
            nxt_wrap = 1'b1;
`endif
          end else begin
            nxt = WIDTH'(cur + ONE);
          end
        end else begin
          if (cur == '0) begin
`ifdef COUNTER_MOD_N_SAT_EN
            nxt = '0;
`else
            nxt      = MAXW;
            nxt_wrap = 1'b1;
`endif
          end else begin
            nxt = WIDTH'(cur - ONE);
          end
        end
      end
      default: begin
        nxt      = OUT;
        nxt_wrap = 1'b0;
      end
    endcase
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT  <= '0;
      WRAP <= 1'b0;
    end else begin
      OUT  <= nxt;
      WRAP <= nxt_wrap;
    end
  end

  // Terminal count feeds the enable of the next cascade stage.
  assign TC = CNT & (UP ? (cur == MAX) : (cur == '0));

endmodule

// File: tb/tb_counter_mod_n.sv
// Directed bench for counter_mod_n: vector table plus
// reset, cascade, full-range and saturating sequences.
module tb_counter_mod_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cnt, up, ld;
  logic [2:0] din;
  logic [2:0] out;
  logic       tc, wrap;

  logic       c_cnt;
  logic [2:0] c_out0, c_out1;
  logic       c_tc0, c_tc1, c_wrap0, c_wrap1;

  logic       w_cnt, w_ld;
  logic [3:0] w_din, w_out;
  logic       w_tc, w_wrap;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  counter_mod_n #(.WIDTH(3), .MODULUS(6)) dut (
    .CLK(clk), .RST_N(rst_n), .CNT(cnt), .UP(up),
    .LD(ld), .DIN(din), .OUT(out), .TC(tc),
    .WRAP(wrap)
  );

  counter_mod_n #(.WIDTH(3), .MODULUS(6)) c0 (
    .CLK(clk), .RST_N(rst_n), .CNT(c_cnt),
    .UP(1'b1), .LD(1'b0), .DIN(3'd0),
    .OUT(c_out0), .TC(c_tc0), .WRAP(c_wrap0)
  );

  counter_mod_n #(.WIDTH(3), .MODULUS(6)) c1 (
    .CLK(clk), .RST_N(rst_n), .CNT(c_tc0),
    .UP(1'b1), .LD(1'b0), .DIN(3'd0),
    .OUT(c_out1), .TC(c_tc1), .WRAP(c_wrap1)
  );

  counter_mod_n #(.WIDTH(4), .MODULUS(16)) w16 (
    .CLK(clk), .RST_N(rst_n), .CNT(w_cnt),
    .UP(1'b1), .LD(w_ld), .DIN(w_din),
    .OUT(w_out), .TC(w_tc), .WRAP(w_wrap)
  );

  typedef struct {
    logic       ld;
    logic       cnt;
    logic       up;
    logic [2:0] din;
    logic [2:0] e_out;
    logic       e_wrap;
    logic       e_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name,
                       input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic l, input logic c,
                     input logic u, input logic [2:0] d,
                     input logic [2:0] eo, input logic ew,
                     input logic et);
    vec_t v;
    v.ld = l; v.cnt = c; v.up = u; v.din = d;
    v.e_out = eo; v.e_wrap = ew; v.e_tc = et;
    vecs.push_back(v);
  endtask

  int wraps;
  int exp_v;

  initial begin
    rst_n = 1'b0; cnt = 0; up = 1; ld = 0; din = 0;
    c_cnt = 0; w_cnt = 0; w_ld = 0; w_din = 0;

    // up through the wrap
    add(0,1,1,0, 1,0,0); add(0,1,1,0, 2,0,0);
    add(0,1,1,0, 3,0,0); add(0,1,1,0, 4,0,0);
    add(0,1,1,0, 5,0,1); add(0,1,1,0, 0,1,0);
    add(0,1,1,0, 1,0,0);
    // load 3 then count down through the wrap
    add(1,0,1,3, 3,0,0);
    add(0,1,0,0, 2,0,0); add(0,1,0,0, 1,0,0);
    add(0,1,0,0, 0,0,1); add(0,1,0,0, 5,1,0);
    add(0,1,0,0, 4,0,0);
    // load clamp
    add(1,0,1,7, 5,0,0);
    // LD beats CNT
    add(1,0,1,4, 4,0,0);
    add(1,1,1,2, 2,0,0);
    add(0,0,1,0, 2,0,0);
    // down wrap then hold clears WRAP
    add(1,0,0,0, 0,0,0);
    add(0,1,0,0, 5,1,0);
    add(0,0,0,0, 5,0,0);
    // DIN==MODULUS clamps; back-to-back wraps with UP flip
    add(1,0,1,6, 5,0,0);
    add(0,1,1,0, 0,1,0);
    add(0,1,0,0, 5,1,0);

    #2;
    check("reset_out", out, 0);
    check("reset_wrap", wrap, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // async reset mid-count, no edge needed
    cnt = 1; up = 1;
    repeat (4) step();
    check("pre_rst_out", out, 4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", out, 0);
    check("async_rst_wrap", wrap, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("post_rst_count", out, i);
    end
    step(); step(); step();
    check("pend_wrap", wrap, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_clr_wrap", wrap, 0);
    check("rst_clr_out", out, 0);
    cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      ld = vecs[i].ld; cnt = vecs[i].cnt;
      up = vecs[i].up; din = vecs[i].din;
      step();
      check($sformatf("vec%0d_out", i),
            out, vecs[i].e_out);
      check($sformatf("vec%0d_wrap", i),
            wrap, vecs[i].e_wrap);
      check($sformatf("vec%0d_tc", i),
            tc, vecs[i].e_tc);
    end
    ld = 0; cnt = 0;

    // two-stage cascade, 36 edges
    wraps = 0;
    c_cnt = 1;
    for (int k = 1; k <= 36; k++) begin
      step();
      exp_v = k % 36;
      check($sformatf("casc_%0d", k),
            c_out1 * 6 + c_out0, exp_v);
      if (c_wrap1) wraps++;
    end
    c_cnt = 0;
    check("casc_wrap1_cnt", wraps, 1);

    // MODULUS == 2**WIDTH wraps by overflow
    w_ld = 1; w_din = 4'd14;
    step();
    w_ld = 0; w_cnt = 1;
    step();
    check("w16_out15", w_out, 15);
    check("w16_tc15", w_tc, 1);
    step();
    check("w16_out0", w_out, 0);
    check("w16_wrap", w_wrap, 1);
    step();
    check("w16_out1", w_out, 1);
    check("w16_wrap_clr", w_wrap, 0);
    w_cnt = 0;

`ifdef COUNTER_MOD_N_SAT_EN
    ld = 1; din = 0;
    step();
    ld = 0; cnt = 1; up = 1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("sat_out_%0d", k), out,
            (k > 5) ? 5 : k);
      check($sformatf("sat_wrap_%0d", k), wrap, 0);
    end
    cnt = 0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
